// File: rtl/mmio_output_port.sv
`default_nettype none
// ============================================================================
// mmio_output_port : snoops the data-memory write bus into a 24-bit output
//                    port plus three double-buffered, prescaled 8-bit PWMs.
// Revision 1.0
// ============================================================================
module mmio_output_port #(
    parameter int OUT_ADDR  = 1009,
    parameter int PWM0_ADDR = 1006,
    parameter int PWM1_ADDR = 1003,
    parameter int PWM2_ADDR = 1000,
    parameter int PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  writeAddr,
    input  logic        WE,
    input  logic [23:0] writeData,
    output logic [23:0] outputPort,
    output logic        outStrobe,
    output logic [2:0]  pwmOut,
    output logic        pwmPeriodEnd
);

    localparam int             PSW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PRE_MAX    = PSW'(PRESCALE - 1);
    localparam logic [9:0]     LAST_ADDR  = 10'd1011;
    localparam logic [2:0][9:0] DUTY_ADDR = {10'(PWM2_ADDR), 10'(PWM1_ADDR), 10'(PWM0_ADDR)};

    logic [23:0]     port_q, port_d;
    logic            strobe_q, strobe_d;
    logic [2:0][7:0] shadow_q, shadow_d;
    logic [2:0][7:0] active_q, active_d;
    logic [PSW-1:0]  pre_q, pre_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0]      pwm_q, pwm_d;
    logic            pend_q, pend_d;

    logic            wr_ok;
    logic            tick;
    logic            wrap;
    logic [2:0][9:0] byte_addr;

    always_comb begin
        wr_ok    = WE && (writeAddr <= LAST_ADDR);
        port_d   = port_q;
        strobe_d = 1'b0;
        shadow_d = shadow_q;
        for (int k = 0; k < 3; k++) begin
            // 10-bit add: byte addresses wrap modulo 1024
            byte_addr[k] = writeAddr + 10'(k);
            for (int b = 0; b < 3; b++) begin
                if (wr_ok && byte_addr[k] == 10'(OUT_ADDR + b)) begin
                    port_d[8*b +: 8] = writeData[8*k +: 8];
                    strobe_d         = 1'b1;
                end
            end
            for (int n = 0; n < 3; n++) begin
                if (wr_ok && byte_addr[k] == DUTY_ADDR[n]) begin
                    shadow_d[n] = writeData[8*k +: 8];
                end
            end
        end
    end

    // Active duties only change at the period wrap, so a period never glitches.
    always_comb begin
        tick     = (pre_q == PRE_MAX);
        wrap     = tick && (cnt_q == 8'hFF);
        pre_d    = tick ? '0 : pre_q + 1'b1;
        cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
        active_d = wrap ? shadow_q : active_q;
        pend_d   = wrap;
        for (int n = 0; n < 3; n++) begin
            pwm_d[n] = (cnt_q < active_q[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_q   <= '0;
            strobe_q <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            pre_q    <= '0;
            cnt_q    <= '0;
            pwm_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            port_q   <= port_d;
            strobe_q <= strobe_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            pend_q   <= pend_d;
        end
    end

    assign outputPort   = port_q;
    assign outStrobe    = strobe_q;
    assign pwmOut       = pwm_q;
    assign pwmPeriodEnd = pend_q;

endmodule
`default_nettype wire
